// File: rtl/comp_sum_8_bits.sv
// Registered ripple-carry adder for two unsigned ASCII-width operands.
// One-cycle latency, one result per valid input, no backpressure.
module comp_sum_8_bits #(
   parameter int OPERAND_W = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 Cin,
   input  logic [OPERAND_W-1:0] num_A,
   input  logic [OPERAND_W-1:0] num_B,
   input  logic                 in_valid,
   output logic [OPERAND_W:0]   num_sum,
   output logic                 Cout,
   output logic                 out_valid
);

   logic [OPERAND_W-1:0] sum_bits;
   logic                 carry;
   logic [OPERAND_W:0]   sum_next;

   // Carry ripples cell by cell; blocking updates keep the chain acyclic.
   always_comb begin
      sum_bits = '0;
      carry    = Cin;
      for (int i = 0; i < OPERAND_W; i++) begin
         sum_bits[i] = num_A[i] ^ num_B[i] ^ carry;
         carry       = (num_A[i] & num_B[i]) |
                       (carry & (num_A[i] ^ num_B[i]));
      end
      sum_next = {carry, sum_bits};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_sum   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid)
            num_sum <= sum_next;
      end
   end

   // Carry-out is the stored MSB, so it can never disagree with num_sum.
   assign Cout = num_sum[OPERAND_W];

endmodule

// File: tb/tb_comp_sum_8_bits.sv
// Scoreboard bench for comp_sum_8_bits: driver queues expected sums,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_comp_sum_8_bits;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       Cin;
   logic [6:0] num_A;
   logic [6:0] num_B;
   logic       in_valid;
   logic [7:0] num_sum;
   logic       Cout;
   logic       out_valid;

   int tests  = 0;
   int failed = 0;

   logic [7:0] exp_q[$];

   comp_sum_8_bits #(.OPERAND_W(7)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Cin       (Cin),
      .num_A     (num_A),
      .num_B     (num_B),
      .in_valid  (in_valid),
      .num_sum   (num_sum),
      .Cout      (Cout),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic send(input logic [6:0] a, input logic [6:0] b,
                       input logic c);
      logic [7:0] e;
      num_A    = a;
      num_B    = b;
      Cin      = c;
      in_valid = 1'b1;
      e = {1'b0, a} + {1'b0, b} + {7'd0, c};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      check("cout_eq_msb", int'(Cout), int'(num_sum[7]));
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("sum", int'(num_sum), int'(e));
            check("cout", int'(Cout), int'(e[7]));
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      Cin      = 1'b0;
      num_A    = '0;
      num_B    = '0;
      in_valid = 1'b0;
      #12;
      check("rst_sum", int'(num_sum), 0);
      check("rst_cout", int'(Cout), 0);
      check("rst_valid", int'(out_valid), 0);
      rst_n = 1'b1;

      // First edge after release must already accept data
      send(7'h00, 7'h00, 1'b0);
      check("first_valid", int'(out_valid), 1);
      send(7'h41, 7'h42, 1'b0);
      send(7'h7F, 7'h7F, 1'b1);
      send(7'h7F, 7'h7F, 1'b0);
      send(7'h30, 7'h05, 1'b1);
      check("hold_valid_pulse", int'(out_valid), 1);
      for (int k = 0; k < 3; k++) begin
         idle();
         check("hold_valid_low", int'(out_valid), 0);
         check("hold_sum", int'(num_sum), 'h36);
         check("hold_cout", int'(Cout), 0);
      end

      // Exhaustive back-to-back sweep with Cin alternating
      for (int a = 0; a < 128; a++) begin
         for (int b = 0; b < 128; b++) begin
            send(7'(a), 7'(b), 1'(b));
            check("b2b_valid", int'(out_valid), 1);
         end
      end
      idle();
      check("sweep_end_valid", int'(out_valid), 0);

      // Reset mid-cycle with a result showing and another op in flight
      send(7'h41, 7'h42, 1'b0);
      check("pre_rst_sum", int'(num_sum), 'h83);
      check("pre_rst_valid", int'(out_valid), 1);
      num_A    = 7'h10;
      num_B    = 7'h20;
      Cin      = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_sum", int'(num_sum), 0);
      check("async_rst_cout", int'(Cout), 0);
      check("async_rst_valid", int'(out_valid), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("in_rst_sum", int'(num_sum), 0);
      check("in_rst_valid", int'(out_valid), 0);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_sum", int'(num_sum), 0);
      check("post_rst_valid", int'(out_valid), 0);
      send(7'h12, 7'h34, 1'b1);
      check("post_rst_new_sum", int'(num_sum), 'h47);
      check("post_rst_new_valid", int'(out_valid), 1);
      idle();
      idle();
      check("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
